// File: rtl/xclkmeasure.sv
// Clock-pin monitor fed by 8x ISERDES sample words: per-word rising-edge count,
// edge-to-edge period in samples, windowed edge count (frequency) and stuck flag.
module xclkmeasure #(
    parameter int LGINTERVAL  = 10,
    parameter int STUCK_WORDS = 64,
    parameter int PW          = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  logic [7:0]            i_word,
    output logic                  o_stb,
    output logic [2:0]            o_rises,
    output logic [PW-1:0]         o_period,
    output logic                  o_count_stb,
    output logic [LGINTERVAL+2:0] o_count,
    output logic                  o_stuck,
    output logic                  o_level
);
    localparam int CW = LGINTERVAL + 3;
    localparam int SW = $clog2(STUCK_WORDS + 1);

    logic                  prev;
    logic                  primed;
    logic                  have_edge;
    logic [PW-1:0]         since;
    logic [LGINTERVAL-1:0] win_cnt;
    logic [CW-1:0]         accum;
    logic [SW-1:0]         edgeless;

    logic [7:0]    rise;
    logic [2:0]    n_rise;
    logic [2:0]    p_last;
    logic [2:0]    p_prev;
    logic [PW:0]   run_ext;
    logic [PW:0]   idle_ext;
    logic [PW-1:0] period_val;
    logic [PW-1:0] since_next;

    // rise[p] is indexed by sample position: position 0 is i_word[7] (oldest).
    always_comb begin
        rise    = '0;
        rise[0] = primed & ~prev & i_word[7];
        for (int p = 1; p < 8; p++) begin
            rise[p] = i_word[7-p] & ~i_word[8-p];
        end

        n_rise = '0;
        p_last = '0;
        p_prev = '0;
        for (int p = 0; p < 8; p++) begin
            if (rise[p]) begin
                p_prev = p_last;
                p_last = 3'(p);
                n_rise = n_rise + 3'd1;
            end
        end

        run_ext  = {1'b0, since} + {{(PW-2){1'b0}}, p_last};
        idle_ext = {1'b0, since} + (PW+1)'(8);

        if (n_rise >= 3'd2) begin
            period_val = PW'(p_last - p_prev);
        end else begin
            period_val = run_ext[PW] ? '1 : run_ext[PW-1:0];
        end

        if (n_rise != 3'd0) begin
            since_next = PW'(4'd8 - {1'b0, p_last});
        end else begin
            since_next = idle_ext[PW] ? '1 : idle_ext[PW-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stb       <= 1'b0;
            o_rises     <= '0;
            o_period    <= '0;
            o_count_stb <= 1'b0;
            o_count     <= '0;
            o_stuck     <= 1'b0;
            o_level     <= 1'b0;
            prev        <= 1'b0;
            primed      <= 1'b0;
            have_edge   <= 1'b0;
            since       <= '0;
            win_cnt     <= '0;
            accum       <= '0;
            edgeless    <= '0;
        end else if (i_ce) begin
            o_stb   <= 1'b1;
            o_level <= i_word[0];
            o_rises <= n_rise;
            prev    <= i_word[0];
            primed  <= 1'b1;
            since   <= since_next;

            if (n_rise != 3'd0) begin
                // have_edge is still 0 on the first rise after reset or stuck.
                if (have_edge) begin
                    o_period <= period_val;
                end
                have_edge <= 1'b1;
                o_stuck   <= 1'b0;
                edgeless  <= '0;
            end else if (edgeless != SW'(STUCK_WORDS)) begin
                edgeless <= edgeless + SW'(1);
                if (edgeless == SW'(STUCK_WORDS - 1)) begin
                    o_stuck   <= 1'b1;
                    have_edge <= 1'b0;
                end
            end

            win_cnt <= win_cnt + LGINTERVAL'(1);
            if (win_cnt == '1) begin
                o_count     <= accum + CW'(n_rise);
                o_count_stb <= 1'b1;
                accum       <= '0;
            end else begin
                o_count_stb <= 1'b0;
                accum       <= accum + CW'(n_rise);
            end
        end else begin
            o_stb       <= 1'b0;
            o_count_stb <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xclkmeasure.sv
// Directed bench for xclkmeasure with LGINTERVAL=4, STUCK_WORDS=4, PW=16.
module tb_xclkmeasure;
    localparam int LGI = 4;
    localparam int PW  = 16;

    logic          i_clk;
    logic          i_reset_n;
    logic          i_ce;
    logic [7:0]    i_word;
    logic          o_stb;
    logic [2:0]    o_rises;
    logic [PW-1:0] o_period;
    logic          o_count_stb;
    logic [LGI+2:0] o_count;
    logic          o_stuck;
    logic          o_level;

    int checks = 0;
    int errors = 0;
    logic [LGI+2:0] exp_q[$];

    xclkmeasure #(.LGINTERVAL(LGI), .STUCK_WORDS(4), .PW(PW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_word(i_word),
        .o_stb(o_stb), .o_rises(o_rises), .o_period(o_period),
        .o_count_stb(o_count_stb), .o_count(o_count), .o_stuck(o_stuck),
        .o_level(o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"}, 32'(o_stb), 0);
        check({tag, "_rises"}, 32'(o_rises), 0);
        check({tag, "_period"}, 32'(o_period), 0);
        check({tag, "_cstb"}, 32'(o_count_stb), 0);
        check({tag, "_count"}, 32'(o_count), 0);
        check({tag, "_stuck"}, 32'(o_stuck), 0);
        check({tag, "_level"}, 32'(o_level), 0);
    endtask

    task automatic do_reset();
        i_ce = 1'b0;
        i_word = 8'h00;
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        exp_q.delete();
    endtask

    // One accepted word; returns 1 ns after the edge that latches it.
    task automatic send(input logic [7:0] w);
        @(negedge i_clk);
        i_ce = 1'b1;
        i_word = w;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_ce = 1'b0;
        i_word = 8'hA5;
        @(posedge i_clk);
        #1;
        check("idle_stb", 32'(o_stb), 0);
        check("idle_cstb", 32'(o_count_stb), 0);
    endtask

    task automatic pop_count(input string tag);
        if (o_count_stb) begin
            if (exp_q.size() == 0) check({tag, "_extra_cstb"}, 1, 0);
            else check({tag, "_count"}, 32'(o_count), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_f0(input bit gap);
        do_reset();
        exp_q.push_back(15);
        exp_q.push_back(16);
        for (int k = 0; k < 34; k++) begin
            send(8'hF0);
            check("f0_stb", 32'(o_stb), 1);
            check("f0_rises", 32'(o_rises), (k == 0) ? 0 : 1);
            check("f0_period", 32'(o_period), (k >= 2) ? 8 : 0);
            check("f0_level", 32'(o_level), 0);
            check("f0_cstb", 32'(o_count_stb), ((k % 16) == 15) ? 1 : 0);
            pop_count("f0");
            if (gap) idle();
        end
        check("f0_count_left", exp_q.size(), 0);
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_ce = 1'b0;
        i_word = 8'h00;

        run_f0(1'b0);
        run_f0(1'b1);

        // 8'hCC: rises at positions 0 and 4
        do_reset();
        for (int k = 0; k < 32; k++) begin
            send(8'hCC);
            if (k >= 1) begin
                check("cc_rises", 32'(o_rises), 2);
                check("cc_period", 32'(o_period), 4);
            end
            check("cc_cstb", 32'(o_count_stb), ((k % 16) == 15) ? 1 : 0);
            if (k == 31) check("cc_count", 32'(o_count), 32);
        end

        // Alternating FF / 00: one rise every 16 samples
        do_reset();
        for (int k = 0; k < 32; k++) begin
            send((k % 2 == 0) ? 8'hFF : 8'h00);
            check("alt_rises", 32'(o_rises), (k > 0 && k % 2 == 0) ? 1 : 0);
            check("alt_period", 32'(o_period), (k >= 4) ? 16 : 0);
            check("alt_level", 32'(o_level), (k % 2 == 0) ? 1 : 0);
            if (k == 15) check("alt_count1", 32'(o_count), 7);
            if (k == 31) check("alt_count2", 32'(o_count), 8);
        end

        // Stuck detection and recovery
        do_reset();
        repeat (3) send(8'hF0);
        check("stk_period_pre", 32'(o_period), 8);
        for (int k = 0; k < 4; k++) begin
            send(8'h00);
            check("stk_flag", 32'(o_stuck), (k == 3) ? 1 : 0);
            check("stk_rises", 32'(o_rises), 0);
        end
        check("stk_level", 32'(o_level), 0);
        send(8'hF0);
        check("stk_clear", 32'(o_stuck), 0);
        check("stk_period_hold", 32'(o_period), 8);
        send(8'hF0);
        check("stk_period_next", 32'(o_period), 8);

        // Maximum rises per word and intra-word period
        do_reset();
        send(8'h00);
        send(8'hAA);
        check("aa_rises1", 32'(o_rises), 4);
        check("aa_period1", 32'(o_period), 0);
        send(8'hAA);
        check("aa_rises2", 32'(o_rises), 4);
        check("aa_period2", 32'(o_period), 2);

        // Asynchronous reset mid-window
        do_reset();
        for (int k = 0; k < 8; k++) send(8'hF0);
        check("mid_pre_stb", 32'(o_stb), 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_all_zero("async");
        @(negedge i_clk);
        i_ce = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            send(8'hF0);
            check("mid_rises", 32'(o_rises), (k == 0) ? 0 : 1);
            check("mid_cstb", 32'(o_count_stb), (k == 15) ? 1 : 0);
            if (k == 15) check("mid_count", 32'(o_count), 15);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
